yutorina_bus_if: RTL and testbench
==================================

YUTORINA_BUS_IF -- requirements
Module: yutorina_bus_if

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: reset asserts on rst falling edge without waiting for clk.
REQ-002 The block SHALL use these encodings: READ=1, WRITE=0, ENABLE_=0, DISABLE_=1.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-low reset.
REQ-005 stall  in  1  pipeline stall, active-high.
REQ-006 rw  in  1  CPU access direction (READ/WRITE).
REQ-007 as_  in  1  CPU access strobe, active-low.
REQ-008 addr  in  30  CPU word address.
REQ-009 w_data  in  32  CPU write data.
REQ-010 r_data  out  32  CPU read data, combinational.
REQ-011 spm_r_data  in  32  scratch-pad memory (SPM) read data.
REQ-012 spm_addr  out  12  SPM word address.
REQ-013 spm_as_  out  1  SPM strobe, active-low, combinational.
REQ-014 bus_r_data  in  32  system-bus read data.
REQ-015 bus_w_data  out  32  system-bus write data, registered.
REQ-016 bus_rdy_  in  1  bus ready, active-low.
REQ-017 bus_req_  out  1  bus request, active-low, registered.
REQ-018 bus_rw  out  1  bus direction, registered.
REQ-019 bus_addr  out  30  bus word address, registered.
REQ-020 bus_as_  out  1  bus strobe, active-low, registered.
REQ-021 bus_grnt_  in  1  bus grant, active-low.
REQ-022 bus_busy  out  1  access in progress, active-high; the CPU stalls on it; combinational.

Function
REQ-023 The block SHALL decode slave index = addr[29:27] and treat index 3'h1 as the SPM; every other index goes to the system bus.
REQ-024 spm_addr SHALL equal addr[11:0] at all times.
REQ-025 The block SHALL implement a four-state FSM: IDLE, REQ, ACCESS, STALL.
REQ-026 Combinational defaults SHALL be r_data=0, spm_as_=DISABLE_, bus_busy=0.
REQ-027 In IDLE with as_=ENABLE_ and an SPM address: when stall=0, spm_as_=ENABLE_, and on a READ r_data=spm_r_data in the same cycle; the FSM stays in IDLE.
REQ-028 In IDLE with as_=ENABLE_ and a non-SPM address: bus_busy=1 combinationally.
REQ-029 At the same IDLE clock edge, the block SHALL latch bus_addr<=addr, bus_rw<=rw, bus_w_data<=w_data and bus_req_<=ENABLE_, then go to REQ.
REQ-030 In REQ: bus_busy=1; when bus_grnt_=ENABLE_, the block SHALL set bus_as_<=ENABLE_ and go to ACCESS; otherwise it waits in REQ.
REQ-031 In ACCESS: bus_as_<=DISABLE_ on every edge (one-cycle strobe).
REQ-032 In ACCESS with bus_rdy_=DISABLE_: bus_busy=1 and the FSM stays in ACCESS.
REQ-033 In ACCESS with bus_rdy_=ENABLE_: bus_busy=0 and, on a READ, r_data=bus_r_data combinationally.
REQ-034 At that ACCESS edge, the block SHALL set bus_req_<=DISABLE_, bus_addr<=0, bus_rw<=READ, bus_w_data<=0, and on a READ capture rd_buf<=bus_r_data.
REQ-035 From that ACCESS edge, the next state SHALL be STALL if stall=1, otherwise IDLE.
REQ-036 In STALL: on a READ, r_data=rd_buf; bus_busy=0; the FSM returns to IDLE when stall=0.
REQ-037 Writes SHALL never drive r_data non-zero.
REQ-038 as_=DISABLE_ in IDLE SHALL cause no action.

Reset
REQ-039 While rst=0: state=IDLE, bus_req_=1, bus_as_=1, bus_rw=READ, bus_addr=0, bus_w_data=0, rd_buf=0.
REQ-040 A reset mid-transaction SHALL abort the transaction to IDLE immediately, with all outputs at their reset values.

Verification
REQ-041 SPM read: addr=30'h0800_0005, rw=READ, as_=0, stall=0, spm_r_data=32'hDEADBEEF -> spm_as_=0, spm_addr=12'h005, r_data=32'hDEADBEEF, bus_busy=0.
REQ-042 SPM access with stall=1 -> spm_as_=1, r_data=0.
REQ-043 Bus read: addr=30'h0000_0010, grant after 2 cycles, rdy_ after 1 more, bus_r_data=32'h12345678 -> bus_req_=0 from the next cycle and bus_as_=0 for exactly one cycle; busy drops on the rdy_ cycle, r_data=32'h12345678; then bus_req_=1 and bus_addr=0.
REQ-044 Bus write: rw=WRITE, w_data=32'hCAFEF00D -> bus_rw=0 and bus_w_data=32'hCAFEF00D until rdy_; r_data stays 0.
REQ-045 Bus read completing with stall=1 -> FSM in STALL, r_data holds rd_buf value while stalled, IDLE one cycle after stall=0.
REQ-046 Assert rst=0 during REQ -> bus_req_=1 and the FSM in IDLE immediately.

Source files
------------

// File: rtl/yutorina_bus_if.sv
// rtl/yutorina_bus_if.sv - CPU-side bus interface routing accesses to the scratch-pad memory or the system bus
//
// Slave index 1 (addr[29:27]) is the scratch-pad memory, served combinationally in a
// single cycle. Every other index is forwarded to the system bus through a
// request / grant / strobe / ready handshake while bus_busy stalls the CPU.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   stall        pipeline stall, active-high
//   rw           CPU access direction (1 = read, 0 = write)
//   as_          CPU access strobe, active-low
//   addr         CPU word address [29:0]
//   w_data       CPU write data [31:0]
//   r_data       CPU read data [31:0], combinational
//   spm_r_data   SPM read data [31:0]
//   spm_addr     SPM word address [11:0]
//   spm_as_      SPM strobe, active-low, combinational
//   bus_r_data   system-bus read data [31:0]
//   bus_w_data   system-bus write data [31:0], registered
//   bus_rdy_     bus ready, active-low
//   bus_req_     bus request, active-low, registered
//   bus_rw       bus direction, registered
//   bus_addr     bus word address [29:0], registered
//   bus_as_      bus strobe, active-low, registered
//   bus_grnt_    bus grant, active-low
//   bus_busy     access in progress, active-high, combinational

module yutorina_bus_if (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        rw,
   input  logic        as_,
   input  logic [29:0] addr,
   input  logic [31:0] w_data,
   output logic [31:0] r_data,
   input  logic [31:0] spm_r_data,
   output logic [11:0] spm_addr,
   output logic        spm_as_,
   input  logic [31:0] bus_r_data,
   output logic [31:0] bus_w_data,
   input  logic        bus_rdy_,
   output logic        bus_req_,
   output logic        bus_rw,
   output logic [29:0] bus_addr,
   output logic        bus_as_,
   input  logic        bus_grnt_,
   output logic        bus_busy
);

   localparam logic       READ      = 1'b1;
   localparam logic       ENABLE_   = 1'b0;
   localparam logic       DISABLE_  = 1'b1;
   localparam logic [2:0] SPM_INDEX = 3'h1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_ACCESS,
      ST_STALL
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] rd_buf;
   logic        is_spm;

   assign is_spm   = (addr[29:27] == SPM_INDEX);
   assign spm_addr = addr[11:0];

   // The CPU holds rw stable while bus_busy or stall is high, so the live rw
   // still describes the outstanding bus access in ACCESS and STALL.
   always_comb begin
      r_data     = 32'h0;
      spm_as_    = DISABLE_;
      bus_busy   = 1'b0;
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (as_ == ENABLE_) begin
               if (is_spm) begin
                  if (!stall) begin
                     spm_as_ = ENABLE_;
                     if (rw == READ) begin
                        r_data = spm_r_data;
                     end
                  end
               end else begin
                  bus_busy   = 1'b1;
                  state_next = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            bus_busy = 1'b1;
            if (bus_grnt_ == ENABLE_) begin
               state_next = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (bus_rdy_ == ENABLE_) begin
               if (rw == READ) begin
                  r_data = bus_r_data;
               end
               state_next = stall ? ST_STALL : ST_IDLE;
            end else begin
               bus_busy = 1'b1;
            end
         end
         ST_STALL: begin
            // Bus data is gone by now; replay the captured word until the pipeline moves.
            if (rw == READ) begin
               r_data = rd_buf;
            end
            if (!stall) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         bus_req_   <= DISABLE_;
         bus_as_    <= DISABLE_;
         bus_rw     <= READ;
         bus_addr   <= 30'h0;
         bus_w_data <= 32'h0;
         rd_buf     <= 32'h0;
      end else begin
         state <= state_next;
         case (state)
            ST_IDLE: begin
               if (as_ == ENABLE_ && !is_spm) begin
                  bus_addr   <= addr;
                  bus_rw     <= rw;
                  bus_w_data <= w_data;
                  bus_req_   <= ENABLE_;
               end
            end
            ST_REQ: begin
               if (bus_grnt_ == ENABLE_) begin
                  bus_as_ <= ENABLE_;
               end
            end
            ST_ACCESS: begin
               // Strobe is a single-cycle pulse regardless of how long ready takes.
               bus_as_ <= DISABLE_;
               if (bus_rdy_ == ENABLE_) begin
                  bus_req_   <= DISABLE_;
                  bus_addr   <= 30'h0;
                  bus_rw     <= READ;
                  bus_w_data <= 32'h0;
                  if (rw == READ) begin
                     rd_buf <= bus_r_data;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_yutorina_bus_if.sv
// tb/tb_yutorina_bus_if.sv - scoreboard testbench for yutorina_bus_if

module tb_yutorina_bus_if;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        rw = 1'b1;
   logic        as_ = 1'b1;
   logic [29:0] addr = 30'h0;
   logic [31:0] w_data = 32'h0;
   logic [31:0] spm_r_data = 32'h0;
   logic [31:0] bus_r_data = 32'h0;
   logic        bus_rdy_ = 1'b1;
   logic        bus_grnt_ = 1'b1;

   logic [31:0] r_data;
   logic [11:0] spm_addr;
   logic        spm_as_;
   logic [31:0] bus_w_data;
   logic        bus_req_;
   logic        bus_rw;
   logic [29:0] bus_addr;
   logic        bus_as_;
   logic        bus_busy;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [29:0] a;
      logic        r;
      logic [31:0] wd;
      logic [31:0] rd;
   } bus_exp_t;

   typedef struct {
      logic [11:0] a;
      logic [31:0] rd;
   } spm_exp_t;

   bus_exp_t strobe_q[$];
   bus_exp_t done_q[$];
   spm_exp_t spm_q[$];

   yutorina_bus_if dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .rw         (rw),
      .as_        (as_),
      .addr       (addr),
      .w_data     (w_data),
      .r_data     (r_data),
      .spm_r_data (spm_r_data),
      .spm_addr   (spm_addr),
      .spm_as_    (spm_as_),
      .bus_r_data (bus_r_data),
      .bus_w_data (bus_w_data),
      .bus_rdy_   (bus_rdy_),
      .bus_req_   (bus_req_),
      .bus_rw     (bus_rw),
      .bus_addr   (bus_addr),
      .bus_as_    (bus_as_),
      .bus_grnt_  (bus_grnt_),
      .bus_busy   (bus_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every strobe, SPM access and bus completion the DUT presents
   // must match the oldest outstanding expectation.
   logic     prev_as = 1'b1;
   bus_exp_t mb;
   spm_exp_t ms;

   always @(negedge clk) begin
      if (rst) begin
         if (bus_as_ == 1'b0) begin
            check("strobe_single_cycle", prev_as, 1'b1);
            if (strobe_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL strobe_unexpected actual=bus_as_=0 required=no_strobe");
            end else begin
               mb = strobe_q.pop_front();
               check("strobe_addr", bus_addr, mb.a);
               check("strobe_rw", bus_rw, mb.r);
               check("strobe_wdata", bus_w_data, mb.wd);
               check("strobe_req", bus_req_, 1'b0);
            end
         end
         if (bus_req_ == 1'b0 && bus_busy == 1'b0) begin
            if (done_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL done_unexpected actual=completion required=none");
            end else begin
               mb = done_q.pop_front();
               check("done_rdata", r_data, mb.rd);
               check("done_addr", bus_addr, mb.a);
               check("done_rw", bus_rw, mb.r);
               check("done_wdata", bus_w_data, mb.wd);
            end
         end
         if (spm_as_ == 1'b0) begin
            if (spm_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL spm_unexpected actual=spm_as_=0 required=1");
            end else begin
               ms = spm_q.pop_front();
               check("spm_addr", spm_addr, ms.a);
               check("spm_rdata", r_data, ms.rd);
               check("spm_busy", bus_busy, 1'b0);
            end
         end
      end
      prev_as = bus_as_;
   end

   task automatic spm_access(input logic [29:0] a, input logic r, input logic [31:0] d);
      spm_exp_t e;
      e.a  = a[11:0];
      e.rd = r ? d : 32'h0;
      spm_q.push_back(e);
      as_        = 1'b0;
      addr       = a;
      rw         = r;
      stall      = 1'b0;
      w_data     = $urandom;
      spm_r_data = d;
      step();
      as_ = 1'b1;
   endtask

   task automatic spm_stalled(input logic [29:0] a);
      as_        = 1'b0;
      addr       = a;
      rw         = 1'b1;
      stall      = 1'b1;
      spm_r_data = $urandom | 32'h1;
      #2;
      check("spm_stall_as", spm_as_, 1'b1);
      check("spm_stall_rdata", r_data, 32'h0);
      step();
      stall = 1'b0;
      as_   = 1'b1;
   endtask

   task automatic bus_txn(input logic [29:0] a, input logic r, input logic [31:0] wd,
                          input logic [31:0] rd, input int gd, input int rdl, input logic st);
      bus_exp_t    e;
      int          n;
      logic [29:0] sa;
      e.a  = a;
      e.r  = r;
      e.wd = wd;
      e.rd = r ? rd : 32'h0;
      strobe_q.push_back(e);
      done_q.push_back(e);
      as_    = 1'b0;
      addr   = a;
      rw     = r;
      w_data = wd;
      stall  = 1'b0;
      #1;
      check("busy_on_request", bus_busy, 1'b1);
      step();
      check("req_asserted", bus_req_, 1'b0);
      repeat (gd) begin
         check("busy_wait_grant", bus_busy, 1'b1);
         step();
      end
      bus_grnt_ = 1'b0;
      n = 0;
      do begin
         step();
         n++;
      end while (bus_as_ !== 1'b0 && n < 8);
      if (bus_as_ !== 1'b0) check("grant_timeout", bus_as_, 1'b0);
      repeat (rdl) begin
         check("busy_wait_rdy", bus_busy, 1'b1);
         check("wdata_held", bus_w_data, wd);
         step();
      end
      bus_rdy_   = 1'b0;
      bus_r_data = rd;
      stall      = st;
      step();
      bus_rdy_   = 1'b1;
      bus_grnt_  = 1'b1;
      bus_r_data = $urandom;
      check("req_released", bus_req_, 1'b1);
      check("addr_cleared", bus_addr, 30'h0);
      check("rw_idle", bus_rw, 1'b1);
      check("wdata_cleared", bus_w_data, 32'h0);
      if (st) begin
         repeat (2) begin
            check("stall_rdata", r_data, e.rd);
            check("stall_busy", bus_busy, 1'b0);
            step();
         end
         stall = 1'b0;
         step();
         sa = {3'h1, 27'($urandom)};
         spm_access(sa, 1'b1, $urandom);
      end else begin
         as_ = 1'b1;
      end
   endtask

   int          kind;
   logic [2:0]  idx;
   logic [29:0] ra;
   logic        rr;
   logic        rs;

   initial begin
      rst = 1'b0;
      step();
      step();
      check("reset_req", bus_req_, 1'b1);
      check("reset_as", bus_as_, 1'b1);
      check("reset_rw", bus_rw, 1'b1);
      check("reset_addr", bus_addr, 30'h0);
      check("reset_wdata", bus_w_data, 32'h0);
      check("reset_busy", bus_busy, 1'b0);
      check("reset_rdata", r_data, 32'h0);
      check("reset_spm_as", spm_as_, 1'b1);
      rst = 1'b1;
      step();

      addr = 30'h0000_0040;
      rw   = 1'b1;
      repeat (3) step();
      check("idle_no_req", bus_req_, 1'b1);
      check("idle_no_busy", bus_busy, 1'b0);

      spm_access(30'h0800_0005, 1'b1, 32'hDEADBEEF);
      spm_stalled(30'h0800_0005);
      bus_txn(30'h0000_0010, 1'b1, 32'h0, 32'h1234_5678, 2, 1, 1'b0);
      bus_txn(30'h0000_0010, 1'b0, 32'hCAFE_F00D, 32'h1111_2222, 1, 2, 1'b0);
      bus_txn(30'h1000_0100, 1'b1, 32'h0, 32'hA5A5_0F0F, 0, 0, 1'b1);

      as_  = 1'b0;
      addr = 30'h0000_0020;
      rw   = 1'b1;
      step();
      check("req_before_reset", bus_req_, 1'b0);
      rst = 1'b0;
      #1;
      check("reset_req_async", bus_req_, 1'b1);
      check("reset_addr_async", bus_addr, 30'h0);
      addr       = 30'h0800_0007;
      spm_r_data = 32'h0000_55AA;
      #1;
      check("reset_idle_spm", spm_as_, 1'b0);
      as_ = 1'b1;
      step();
      rst = 1'b1;
      step();

      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 3);
         rr   = 1'($urandom_range(0, 1));
         rs   = 1'($urandom_range(0, 1));
         if (kind == 0) begin
            ra = {3'h1, 27'($urandom)};
            spm_access(ra, rr, $urandom);
         end else if (kind == 1) begin
            ra = {3'h1, 27'($urandom)};
            spm_stalled(ra);
         end else begin
            idx = 3'($urandom_range(0, 7));
            if (idx == 3'h1) idx = 3'h0;
            ra = {idx, 27'($urandom)};
            bus_txn(ra, rr, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), rs);
         end
      end

      repeat (3) step();
      check("strobe_q_empty", strobe_q.size(), 0);
      check("done_q_empty", done_q.size(), 0);
      check("spm_q_empty", spm_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
